stripe_scroller: RTL and testbench
==================================

Name: stripe_scroller

Overview:
- Parametrised successor to the single-stripe block generator in the VGA pixel path.
- Holds N_STRIPES independently configurable vertical stripes. Each stripe has its own offset, width, colour, speed and direction.
- Each stripe scrolls horizontally once per frame, with wrap-around at the right edge of the active area.
- Produces a registered 6-bit RRGGBB pixel per col/row from the VGA timing block; output feeds the colour mux ahead of the DAC pins.

Parameters:
- N_STRIPES, 4, number of stripe channels (1..8).
- H_ACTIVE, 640, active pixel columns; wrap modulus for offsets.
- W_BITS, 7, width of stripe_width fields.
- S_BITS, 4, width of per-frame speed field (pixels/frame); 2^S_BITS-1 < H_ACTIVE.
- IDX_BITS, 2, config index width; must be at least clog2(N_STRIPES).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- col  in  10  current pixel column
- row  in  10  current pixel row (passed through only; no row windowing)
- valid  in  1  high in active video area
- frame_tick  in  1  one-cycle pulse once per frame, during blanking
- pause  in  1  high: frame_tick does not move stripes
- cfg_we  in  1  config write strobe
- cfg_idx  in  IDX_BITS  stripe to write
- cfg_offset  in  10  new offset (0..H_ACTIVE-1)
- cfg_width  in  W_BITS  new width; 0 disables stripe
- cfg_color  in  6  new colour RRGGBB
- cfg_speed  in  S_BITS  pixels moved per frame
- cfg_dir  in  1  0 = move right (+), 1 = move left (-)
- block_rgb  out  6  registered pixel colour
- block_hit  out  1  registered: some enabled stripe covers pixel
- out_valid  out  1  valid delayed one cycle

Behaviour:
- Reset (async, rst_n low):
  - block_rgb=0, block_hit=0, out_valid=0.
  - Stripe i: offset = i*(H_ACTIVE/N_STRIPES), width=0, color=0, speed=0, dir=0.
- Reset deasserting mid-frame: outputs start from the first clk edge after release; no partial state survives.
- Coverage of stripe i, computed in 11-bit arithmetic; end = offset + width:
  - If end <= H_ACTIVE: covered iff offset <= col < end.
  - Else (wraps): covered iff col >= offset OR col < end - H_ACTIVE.
  - width=0: never covered.
- Priority: lowest index covering stripe wins. block_rgb = its color, block_hit=1.
- No stripe covers, or valid=0: block_rgb=0, block_hit=0.
- Latency: exactly 1 clk. Inputs col/valid at edge k produce block_rgb/block_hit/out_valid at edge k+1.
- Scroll update on frame_tick=1 and pause=0, for every stripe, in one cycle:
  - dir=0: offset <= (offset + speed) mod H_ACTIVE.
  - dir=1: offset <= (offset - speed) mod H_ACTIVE, i.e. add H_ACTIVE when offset < speed.
- Config write, cfg_we=1: stripe cfg_idx registers all fields at that edge.
  - cfg_offset >= H_ACTIVE is stored as cfg_offset - H_ACTIVE.
  - cfg_idx >= N_STRIPES: write ignored.
- Simultaneous cfg_we and frame_tick on the same stripe: config write wins; that stripe does not scroll this frame. Other stripes scroll normally.
- Offsets update only on frame_tick. Pixel decode always uses current registered state, so a mid-frame config write takes effect from the next pixel.

Test Plan:
- Reset release, stripe0 {offset 100, width 20, color 6'b110000}, valid=1, sweep col 0..639 -> block_rgb=110000 exactly for col 100..119, one cycle after the col is presented; 0 elsewhere.
- Stripe0 {offset 630, width 20}, col sweep -> covered at col 630..639 and 0..9; block_hit=0 at col 10 and 629.
- Stripe0 {offset 5, speed 8, dir 1}, three frame_ticks -> offset 637, 629, 621; with pause=1, next tick -> offset unchanged at 621.
- Stripe1 {100, 20, 001100} and stripe2 {110, 20, 000011} overlap -> col 115 gives 001100, col 125 gives 000011.
- cfg_we to stripe0 (offset 200) in same cycle as frame_tick with stripe0 speed 4 -> offset reads 200; stripe1 (speed 2) still advances by 2.
- valid=0 with col inside an enabled stripe -> block_rgb=0, block_hit=0, out_valid=0 one cycle later. rst_n pulsed mid-line -> outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/stripe_scroller.sv
// Multi-stripe scrolling block generator for the VGA pixel path.
// N_STRIPES vertical stripes, each with its own offset/width/colour/speed/direction, drawn with one-cycle latency.
module stripe_scroller #(
    parameter int N_STRIPES = 4,
    parameter int H_ACTIVE  = 640,
    parameter int W_BITS    = 7,
    parameter int S_BITS    = 4,
    parameter int IDX_BITS  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [9:0]          col,
    input  logic [9:0]          row,
    input  logic                valid,
    input  logic                frame_tick,
    input  logic                pause,
    input  logic                cfg_we,
    input  logic [IDX_BITS-1:0] cfg_idx,
    input  logic [9:0]          cfg_offset,
    input  logic [W_BITS-1:0]   cfg_width,
    input  logic [5:0]          cfg_color,
    input  logic [S_BITS-1:0]   cfg_speed,
    input  logic                cfg_dir,
    output logic [5:0]          block_rgb,
    output logic                block_hit,
    output logic                out_valid
);
    localparam logic [10:0] H_ACT_11 = 11'(H_ACTIVE);
    localparam int          STEP     = H_ACTIVE / N_STRIPES;

    logic [9:0]        r_offset [N_STRIPES];
    logic [W_BITS-1:0] r_width  [N_STRIPES];
    logic [5:0]        r_color  [N_STRIPES];
    logic [S_BITS-1:0] r_speed  [N_STRIPES];
    logic              r_dir    [N_STRIPES];

    logic [N_STRIPES-1:0] w_cover;
    logic [N_STRIPES-1:0] w_wr;
    logic [9:0]           w_scrolled [N_STRIPES];
    logic [9:0]           w_cfg_offset;
    logic [10:0]          w_col;
    logic [5:0]           w_rgb;
    logic                 w_hit;
    logic                 w_unused;

    // Row is carried for interface symmetry with the timing block; stripes span full height.
    assign w_unused = ^row;
    assign w_col    = {1'b0, col};

    assign w_cfg_offset = ({1'b0, cfg_offset} >= H_ACT_11)
                        ? 10'({1'b0, cfg_offset} - H_ACT_11)
                        : cfg_offset;

    for (genvar g = 0; g < N_STRIPES; g++) begin : g_stripe
        logic [10:0] w_start;
        logic [10:0] w_end;
        logic [10:0] w_fwd;
        logic [10:0] w_bwd;
        logic [10:0] w_spd;

        assign w_start = {1'b0, r_offset[g]};
        assign w_end   = w_start + 11'(r_width[g]);
        assign w_spd   = 11'(r_speed[g]);
        assign w_fwd   = w_start + w_spd;
        assign w_bwd   = w_start - w_spd;

        // A stripe whose end passes H_ACTIVE splits into a right-edge part and a left-edge part.
        assign w_cover[g] = (r_width[g] == '0)  ? 1'b0 :
                            (w_end <= H_ACT_11) ? ((w_col >= w_start) && (w_col < w_end)) :
                                                  ((w_col >= w_start) || (w_col < (w_end - H_ACT_11)));

        // Backward underflow wraps mod 2^11; adding H_ACTIVE lands back in range.
        assign w_scrolled[g] = r_dir[g]
                             ? ((w_start < w_spd) ? 10'(w_bwd + H_ACT_11) : 10'(w_bwd))
                             : ((w_fwd >= H_ACT_11) ? 10'(w_fwd - H_ACT_11) : 10'(w_fwd));

        assign w_wr[g] = cfg_we && (cfg_idx == IDX_BITS'(g));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_STRIPES; i++) begin
                r_offset[i] <= 10'(i * STEP);
                r_width[i]  <= '0;
                r_color[i]  <= '0;
                r_speed[i]  <= '0;
                r_dir[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N_STRIPES; i++) begin
                if (w_wr[i]) begin
                    r_offset[i] <= w_cfg_offset;
                    r_width[i]  <= cfg_width;
                    r_color[i]  <= cfg_color;
                    r_speed[i]  <= cfg_speed;
                    r_dir[i]    <= cfg_dir;
                end else if (frame_tick && !pause) begin
                    r_offset[i] <= w_scrolled[i];
                end
            end
        end
    end

    // Scan from the top index down so the lowest covering stripe is written last and wins.
    always_comb begin
        w_rgb = '0;
        w_hit = 1'b0;
        for (int i = N_STRIPES - 1; i >= 0; i--) begin
            if (w_cover[i]) begin
                w_rgb = r_color[i];
                w_hit = 1'b1;
            end
        end
        if (!valid) begin
            w_rgb = '0;
            w_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block_rgb <= '0;
            block_hit <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            block_rgb <= w_rgb;
            block_hit <= w_hit;
            out_valid <= valid;
        end
    end
endmodule

// File: tb/tb_stripe_scroller.sv
// Directed bench for stripe_scroller: decode sweeps, wrap, scroll, priority, config/tick collision, reset.
module tb_stripe_scroller;
  logic       clk;
  logic       rst_n;
  logic [9:0] col;
  logic [9:0] row;
  logic       valid;
  logic       frame_tick;
  logic       pause;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [9:0] cfg_offset;
  logic [6:0] cfg_width;
  logic [5:0] cfg_color;
  logic [3:0] cfg_speed;
  logic       cfg_dir;
  logic [5:0] block_rgb;
  logic       block_hit;
  logic       out_valid;

  int n_cmp;
  int n_err;

  stripe_scroller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .col        (col),
    .row        (row),
    .valid      (valid),
    .frame_tick (frame_tick),
    .pause      (pause),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_offset (cfg_offset),
    .cfg_width  (cfg_width),
    .cfg_color  (cfg_color),
    .cfg_speed  (cfg_speed),
    .cfg_dir    (cfg_dir),
    .block_rgb  (block_rgb),
    .block_hit  (block_hit),
    .out_valid  (out_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the active edge
  task automatic pix(input int c, input logic v);
    col   = 10'(c);
    valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int idx, input int off, input int w, input logic [5:0] color,
                     input int spd, input logic dir);
    cfg_we     = 1'b1;
    cfg_idx    = 2'(idx);
    cfg_offset = 10'(off);
    cfg_width  = 7'(w);
    cfg_color  = color;
    cfg_speed  = 4'(spd);
    cfg_dir    = dir;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic tick(input logic p);
    frame_tick = 1'b1;
    pause      = p;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    pause      = 1'b0;
  endtask

  initial begin
    logic [5:0] exp_rgb;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    col = '0; row = 10'd7; valid = 1'b0;
    frame_tick = 1'b0; pause = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_offset = '0; cfg_width = '0;
    cfg_color = '0; cfg_speed = '0; cfg_dir = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    check("rst_rgb", 16'(block_rgb), 16'd0);
    check("rst_hit", 16'(block_hit), 16'd0);
    check("rst_ovalid", 16'(out_valid), 16'd0);
    check("rst_off0", 16'(dut.r_offset[0]), 16'd0);
    check("rst_off1", 16'(dut.r_offset[1]), 16'd160);
    check("rst_off2", 16'(dut.r_offset[2]), 16'd320);
    check("rst_off3", 16'(dut.r_offset[3]), 16'd480);
    rst_n = 1'b1;

    // plain stripe at 100..119
    cfg(0, 100, 20, 6'b110000, 0, 1'b0);
    for (int c = 0; c < 640; c++) begin
      pix(c, 1'b1);
      exp_rgb = (c >= 100 && c < 120) ? 6'b110000 : 6'b000000;
      check("sweep1_rgb", 16'(block_rgb), 16'(exp_rgb));
      check("sweep1_hit", 16'(block_hit), 16'(exp_rgb != 0));
    end

    // wrapping stripe 630..639, 0..9
    cfg(0, 630, 20, 6'b110000, 0, 1'b0);
    for (int c = 0; c < 640; c++) begin
      pix(c, 1'b1);
      exp_rgb = (c >= 630 || c < 10) ? 6'b110000 : 6'b000000;
      check("sweep2_rgb", 16'(block_rgb), 16'(exp_rgb));
      check("sweep2_hit", 16'(block_hit), 16'(exp_rgb != 0));
    end

    // leftward scroll with wrap, then pause
    valid = 1'b0;
    cfg(0, 5, 20, 6'b110000, 8, 1'b1);
    tick(1'b0);
    check("scroll_t1", 16'(dut.r_offset[0]), 16'd637);
    tick(1'b0);
    check("scroll_t2", 16'(dut.r_offset[0]), 16'd629);
    tick(1'b0);
    check("scroll_t3", 16'(dut.r_offset[0]), 16'd621);
    tick(1'b1);
    check("scroll_pause", 16'(dut.r_offset[0]), 16'd621);
    check("scroll_other", 16'(dut.r_offset[2]), 16'd320);

    // overlapping stripes: lower index wins
    cfg(0, 0, 0, 6'b000000, 0, 1'b0);
    cfg(1, 100, 20, 6'b001100, 0, 1'b0);
    cfg(2, 110, 20, 6'b000011, 0, 1'b0);
    pix(105, 1'b1); check("ovl_105", 16'(block_rgb), 16'(6'b001100));
    pix(115, 1'b1); check("ovl_115", 16'(block_rgb), 16'(6'b001100));
    pix(125, 1'b1); check("ovl_125", 16'(block_rgb), 16'(6'b000011));
    pix(130, 1'b1); check("ovl_130", 16'(block_rgb), 16'd0);
    check("ovl_130_hit", 16'(block_hit), 16'd0);

    // out-of-range offset folds back into the active area
    cfg(3, 700, 5, 6'b111111, 0, 1'b0);
    check("fold_off3", 16'(dut.r_offset[3]), 16'd60);
    pix(59, 1'b1); check("fold_59", 16'(block_rgb), 16'd0);
    pix(60, 1'b1); check("fold_60", 16'(block_rgb), 16'(6'b111111));
    pix(64, 1'b1); check("fold_64", 16'(block_rgb), 16'(6'b111111));
    pix(65, 1'b1); check("fold_65", 16'(block_rgb), 16'd0);

    // config write collides with frame_tick on stripe 0
    valid = 1'b0;
    cfg(0, 300, 0, 6'b000000, 4, 1'b0);
    cfg(1, 100, 20, 6'b001100, 2, 1'b0);
    cfg(3, 638, 5, 6'b111111, 5, 1'b0);
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_offset = 10'd200; cfg_width = 7'd0;
    cfg_color = 6'd0; cfg_speed = 4'd4; cfg_dir = 1'b0;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0; frame_tick = 1'b0;
    check("coll_off0", 16'(dut.r_offset[0]), 16'd200);
    check("coll_off1", 16'(dut.r_offset[1]), 16'd102);
    check("coll_off2", 16'(dut.r_offset[2]), 16'd110);
    check("coll_off3", 16'(dut.r_offset[3]), 16'd3);
    pix(101, 1'b1); check("coll_101", 16'(block_rgb), 16'd0);
    pix(102, 1'b1); check("coll_102", 16'(block_rgb), 16'(6'b001100));
    pix(2, 1'b1);   check("coll_2", 16'(block_rgb), 16'd0);
    pix(3, 1'b1);   check("coll_3", 16'(block_rgb), 16'(6'b111111));

    // one-cycle latency: output holds until the next edge
    pix(115, 1'b1);
    check("lat_115", 16'(block_rgb), 16'(6'b001100));
    check("lat_ovalid", 16'(out_valid), 16'd1);
    col = 10'd125;
    #1;
    check("lat_hold", 16'(block_rgb), 16'(6'b001100));
    @(posedge clk);
    #1;
    check("lat_125", 16'(block_rgb), 16'(6'b000011));

    // valid low blanks the output
    pix(115, 1'b0);
    check("blank_rgb", 16'(block_rgb), 16'd0);
    check("blank_hit", 16'(block_hit), 16'd0);
    check("blank_ovalid", 16'(out_valid), 16'd0);

    // asynchronous reset mid-line
    pix(115, 1'b1);
    check("pre_rst_rgb", 16'(block_rgb), 16'(6'b001100));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rgb", 16'(block_rgb), 16'd0);
    check("arst_hit", 16'(block_hit), 16'd0);
    check("arst_ovalid", 16'(out_valid), 16'd0);
    check("arst_off1", 16'(dut.r_offset[1]), 16'd160);
    #2;
    rst_n = 1'b1;
    pix(115, 1'b1);
    check("post_rst_rgb", 16'(block_rgb), 16'd0);
    check("post_rst_hit", 16'(block_hit), 16'd0);
    check("post_rst_ovalid", 16'(out_valid), 16'd1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
